cooling_sensor_scanner: RTL



---
 rtl/cooling_sensor_scanner_pkg.sv | 25 ++
 rtl/cooling_sensor_scanner.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cooling_sensor_scanner_pkg.sv
// Shared definitions for the cooling sensor scanner: channel indices,
// scanner states and the dwell-counter compare helper.
package cooling_pkg;

    localparam int DATA_W_DEFAULT = 3;

    localparam logic [1:0] CH_CALORIE  = 2'd0;
    localparam logic [1:0] CH_TEMP     = 2'd1;
    localparam logic [1:0] CH_PRESSURE = 2'd2;
    localparam logic [1:0] CH_AIR      = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        GAP
    } scan_state_e;

    // True in the last cycle of a dwell of 'limit' cycles; a limit of 0 behaves as 1.
    function automatic logic dwell_done(input logic [3:0] cnt, input logic [4:0] limit);
        return ({1'b0, cnt} + 5'd1) >= limit;
    endfunction

endpackage

// File: rtl/cooling_sensor_scanner.sv
// Round-robin scanner for one shared ADC feeding the cooling FSM's four
// sensor registers, with per-channel timeout faults and a scan-complete pulse.
module cooling_sensor_scanner
    import cooling_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 7,
    parameter int SCAN_GAP    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [1:0]        adc_sel,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] calorie,
    output logic [DATA_W-1:0] temperature,
    output logic [DATA_W-1:0] pressure,
    output logic [DATA_W-1:0] air_pressure,
    output logic              scan_valid,
    output logic [3:0]        sensor_fault,
    output logic              busy
);

    localparam logic [4:0] SETTLE_LIM  = 5'(SETTLE_CYC);
    localparam logic [4:0] TIMEOUT_LIM = 5'(TIMEOUT_CYC);
    localparam logic [4:0] GAP_LIM     = 5'(SCAN_GAP);

    scan_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        chan_q, chan_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q [4];
    logic [DATA_W-1:0] data_d [4];
    logic [3:0]        fault_q, fault_d;
    logic              scan_valid_q, scan_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            chan_q       <= CH_CALORIE;
            sel_q        <= CH_CALORIE;
            fault_q      <= '0;
            scan_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            chan_q       <= chan_d;
            sel_q        <= sel_d;
            fault_q      <= fault_d;
            scan_valid_q <= scan_valid_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // One dwell counter serves SELECT, WAIT and GAP; it restarts on every state change.
    always_comb begin
        logic finish;
        state_d      = state_q;
        chan_d       = chan_q;
        sel_d        = sel_q;
        fault_d      = fault_q;
        scan_valid_d = 1'b0;
        finish       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SELECT;
                    chan_d  = CH_CALORIE;
                    sel_d   = CH_CALORIE;
                end
            end
            SELECT: begin
                if (dwell_done(cnt_q, SETTLE_LIM)) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (adc_done) begin
                    data_d[chan_q]  = adc_data;
                    fault_d[chan_q] = 1'b0;
                    finish          = 1'b1;
                end else if (dwell_done(cnt_q, TIMEOUT_LIM)) begin
                    fault_d[chan_q] = 1'b1;
                    finish          = 1'b1;
                end
                if (finish) begin
                    if (chan_q == CH_AIR) begin
                        state_d      = GAP;
                        scan_valid_d = 1'b1;
                    end else begin
                        state_d = SELECT;
                        chan_d  = chan_q + 2'd1;
                        sel_d   = chan_q + 2'd1;
                    end
                end
            end
            GAP: begin
                if (dwell_done(cnt_q, GAP_LIM)) begin
                    if (enable) begin
                        state_d = SELECT;
                        chan_d  = CH_CALORIE;
                        sel_d   = CH_CALORIE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == 4'hF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        adc_start = (state_q == START);
        busy      = (state_q != IDLE);
    end

    assign adc_sel      = sel_q;
    assign scan_valid   = scan_valid_q;
    assign sensor_fault = fault_q;
    assign calorie      = data_q[CH_CALORIE];
    assign temperature  = data_q[CH_TEMP];
    assign pressure     = data_q[CH_PRESSURE];
    assign air_pressure = data_q[CH_AIR];

endmodule
